note_scroller: RTL and testbench

- Upstream feeder for the VGA note renderer in the Guitar Hero design.
- Fetches 4-lane note words from the chart ROM (Notes.mem image) at song tempo and keeps a window of on-screen note slots.
- The window scrolls one pixel per tick; the renderer reads slot contents and the sub-slot offset.
- Resolves PS2 key strobes against the hit zone and emits hit/miss pulses and a score.

---
 rtl/note_pkg.sv | 18 +
 rtl/note_scroller_if.sv | 29 ++
 rtl/note_scroller_tick_gen.sv | 27 ++
 rtl/note_scroller.sv | 144 ++++++++++++++
 tb/tb_note_scroller.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/note_pkg.sv
// Shared constants, the note word type and the FSM state encoding for note_scroller.
package note_pkg;
  localparam int LANES               = 4;
  localparam int MAX_NOTES_ON_SCREEN = 21;
  localparam int SLOT_HEIGHT         = 32;
  localparam int TICK_DIV            = 1666667;
  localparam int CHART_DEPTH         = 256;

  typedef logic [LANES-1:0] note_t;

  typedef enum logic [2:0] {
    ST_PREFETCH,
    ST_WAIT,
    ST_READY,
    ST_SHIFT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/note_scroller_if.sv
// Bus between note_scroller and its surroundings: chart ROM port, renderer read
// port, PS2 key strobes and the hit/miss/score results.
// slave = the scroller core, master = the environment driving it.
interface note_scroller_if;
  import note_pkg::*;

  logic        run;
  logic [7:0]  chart_addr;
  note_t       chart_data;
  logic [4:0]  rd_slot;
  note_t       rd_notes;
  logic [4:0]  scroll_offset;
  note_t       key_strobe;
  logic        hit;
  logic        miss;
  note_t       hit_lanes;
  logic [15:0] score;
  logic        chart_done;

  modport master (
    output run, chart_data, rd_slot, key_strobe,
    input  chart_addr, rd_notes, scroll_offset, hit, miss, hit_lanes, score, chart_done
  );

  modport slave (
    input  run, chart_data, rd_slot, key_strobe,
    output chart_addr, rd_notes, scroll_offset, hit, miss, hit_lanes, score, chart_done
  );
endinterface

// File: rtl/note_scroller_tick_gen.sv
// scroll_tick_gen: divides clk by TICK_DIV while enabled; o_tick is high for one
// cycle each time the counter sits at its terminal value. Counter freezes when
// i_en is low.
module scroll_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == TC);

  // Free-running divider, cleared on reset, held while disabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == TC) ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/note_scroller.sv
// note_scroller: fetches chart words, scrolls the on-screen note window one pixel
// per tick, and resolves key strobes against the hit zone.
// Optional build macro WIDE_HIT_WINDOW_EN: hit zone also covers the slot above
// the bottom one (bottom slot wins per lane).
//
// state    | meaning
// PREFETCH | chart_addr presented to the ROM
// WAIT     | ROM latency; next_note latched (zero once the chart is exhausted)
// READY    | waiting for the tick that wraps scroll_offset
// SHIFT    | window moves down one slot, next_note enters at the top
// DONE     | chart exhausted and window empty; keeps shifting zeros
module note_scroller import note_pkg::*; #(
  parameter int TICK_DIV_CFG    = TICK_DIV,
  parameter int SLOT_HEIGHT_CFG = SLOT_HEIGHT,
  parameter int CHART_DEPTH_CFG = CHART_DEPTH
) (
  input logic             clk,
  input logic             reset,
  note_scroller_if.slave  bus
);
  localparam int MAX = MAX_NOTES_ON_SCREEN;
  // One extra bit so the address can rest at CHART_DEPTH (256 by default).
  localparam logic [8:0] DEPTH9   = 9'(CHART_DEPTH_CFG);
  localparam logic [4:0] OFF_LAST = 5'(SLOT_HEIGHT_CFG - 1);

  note_t       r_slot [MAX];
  note_t       r_next_note;
  logic [8:0]  r_chart_addr;
  logic [4:0]  r_offset;
  state_t      r_state;
  logic        r_hit;
  logic        r_miss;
  note_t       r_hit_lanes;
  logic [15:0] r_score;
  logic        r_done;

  logic  w_tick;
  logic  w_wrap;
  logic  w_empty;
  logic  w_do_shift;
  note_t w_m_last;
  note_t w_m_prev;
  note_t w_last_after;
  note_t w_prev_after;

  scroll_tick_gen #(.TICK_DIV(TICK_DIV_CFG)) u_tick (
    .clk   (clk),
    .reset (reset),
    .i_en  (bus.run),
    .o_tick(w_tick)
  );

  assign w_wrap     = w_tick && (r_offset == OFF_LAST);
  assign w_do_shift = (r_state == ST_SHIFT) || ((r_state == ST_DONE) && w_wrap);

  // Hit-zone match; bottom slot has per-lane priority over the one above it.
  always_comb begin
    w_m_last = bus.key_strobe & r_slot[MAX-1];
`ifdef WIDE_HIT_WINDOW_EN
    w_m_prev = bus.key_strobe & ~r_slot[MAX-1] & r_slot[MAX-2];
`else
    w_m_prev = '0;
`endif
    w_last_after = r_slot[MAX-1] & ~w_m_last;
    w_prev_after = r_slot[MAX-2] & ~w_m_prev;
  end

  // Window-empty detect for chart_done.
  always_comb begin
    w_empty = 1'b1;
    for (int k = 0; k < MAX; k++) begin
      if (r_slot[k] != '0) w_empty = 1'b0;
    end
  end

  // Renderer read port; out-of-range slots read as empty.
  always_comb begin
    bus.rd_notes = '0;
    if (bus.rd_slot < 5'(MAX)) bus.rd_notes = r_slot[bus.rd_slot];
  end

  assign bus.chart_addr    = r_chart_addr[7:0];
  assign bus.scroll_offset = r_offset;
  assign bus.hit           = r_hit;
  assign bus.miss          = r_miss;
  assign bus.hit_lanes     = r_hit_lanes;
  assign bus.score         = r_score;
  assign bus.chart_done    = r_done;

  // Sequencer, window storage, hit/miss resolution and score.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < MAX; k++) r_slot[k] <= '0;
      r_next_note  <= '0;
      r_chart_addr <= '0;
      r_offset     <= '0;
      r_state      <= ST_PREFETCH;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_hit_lanes  <= '0;
      r_score      <= '0;
      r_done       <= 1'b0;
    end else begin
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_hit_lanes <= '0;

      if (w_tick) r_offset <= (r_offset + 5'd1) & OFF_LAST;

      if ((w_m_last | w_m_prev) != '0) begin
        r_slot[MAX-1] <= w_last_after;
        r_slot[MAX-2] <= w_prev_after;
        r_hit         <= 1'b1;
        r_hit_lanes   <= w_m_last | w_m_prev;
        if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
      end

      // The shift overrides the hit clears above; cleared bits travel via w_*_after.
      if (w_do_shift) begin
        for (int k = MAX-2; k >= 1; k--) r_slot[k] <= r_slot[k-1];
        r_slot[MAX-1] <= w_prev_after;
        r_slot[0]     <= (r_state == ST_DONE) ? '0 : r_next_note;
        r_miss        <= (w_last_after != '0);
        if (r_chart_addr != DEPTH9) r_chart_addr <= r_chart_addr + 9'd1;
      end

      case (r_state)
        ST_PREFETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_next_note <= (r_chart_addr == DEPTH9) ? '0 : bus.chart_data;
          r_state     <= ST_READY;
        end
        ST_READY:    if (w_wrap) r_state <= ST_SHIFT;
        ST_SHIFT:    r_state <= ST_PREFETCH;
        default:     r_state <= ST_DONE;
      endcase

      if ((r_chart_addr == DEPTH9) && w_empty) begin
        r_done  <= 1'b1;
        r_state <= ST_DONE;
      end
    end
  end
endmodule

// File: tb/tb_note_scroller.sv
// Bench for note_scroller with TICK_DIV=4, SLOT_HEIGHT=4, CHART_DEPTH=8.
// Shift j lands on posedge 16*j+1 counted from reset release.
module tb_note_scroller;
  import note_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  note_scroller_if bus();

  note_scroller #(
    .TICK_DIV_CFG   (4),
    .SLOT_HEIGHT_CFG(4),
    .CHART_DEPTH_CFG(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

  note_t rom [8];
  always @(posedge clk) bus.chart_data <= rom[bus.chart_addr[2:0]];

  typedef struct packed {
    logic        hit;
    logic        miss;
    note_t       lanes;
    logic [15:0] score;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every hit/miss pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.hit || bus.miss) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got hit=%b miss=%b lanes=%b score=%0d expected none",
                 bus.hit, bus.miss, bus.hit_lanes, bus.score);
      end else begin
        chk("event{hit,miss,lanes,score}",
            32'({bus.hit, bus.miss, bus.hit_lanes, bus.score}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic expect_ev(input logic h, input logic m, input note_t l, input logic [15:0] s);
    ev_t e;
    e = '{hit: h, miss: m, lanes: l, score: s};
    exp_q.push_back(e);
  endtask

  task automatic at_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL schedule: got cycle %0d expected %0d", cyc, n);
    end
  endtask

  task automatic read_slot(input int k, output note_t v);
    bus.rd_slot = 5'(k);
    #1;
    v = bus.rd_notes;
  endtask

  task automatic strobe_at(input int n, input note_t s);
    at_cyc(n);
    bus.key_strobe = s;
    @(posedge clk);
    #1;
    bus.key_strobe = '0;
  endtask

  task automatic load_rom(input note_t v0, input note_t v1, input note_t v2, input note_t vr);
    rom[0] = v0;
    rom[1] = v1;
    rom[2] = v2;
    for (int i = 3; i < 8; i++) rom[i] = vr;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.key_strobe = '0;
    bus.run = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    note_t v;
    bus.run = 1'b1;
    bus.key_strobe = '0;
    bus.rd_slot = 5'd20;

    // Test 1: single note scrolls to the hit zone and is missed.
    load_rom(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    do_reset();
    chk("reset_score", 32'(bus.score), 32'd0);
    chk("reset_addr", 32'(bus.chart_addr), 32'd0);
    chk("reset_offset", 32'(bus.scroll_offset), 32'd0);
    chk("reset_done", 32'(bus.chart_done), 32'd0);
    at_cyc(337);
    read_slot(20, v);  chk("t1_slot20", 32'(v), 32'b1000);
    read_slot(19, v);  chk("t1_slot19", 32'(v), 32'b0000);
    read_slot(31, v);  chk("t1_slot31", 32'(v), 32'b0000);
    chk("t1_addr_sat", 32'(bus.chart_addr), 32'd8);
    chk("t1_offset", 32'(bus.scroll_offset), 32'd0);
    expect_ev(1'b0, 1'b1, 4'b0000, 16'd0);
    at_cyc(353);
    chk("t1_done_low", 32'(bus.chart_done), 32'd0);
    at_cyc(354);
    chk("t1_done_high", 32'(bus.chart_done), 32'd1);
    read_slot(20, v);  chk("t1_slot20_gone", 32'(v), 32'b0000);

    // Test 2: partial hit, empty-lane strobe ignored, remainder missed.
    load_rom(4'b0101, 4'b0000, 4'b0000, 4'b0000);
    do_reset();
    bus.rd_slot = 5'd20;
    strobe_at(337, 4'b1010);
    read_slot(20, v);  chk("t2_empty_strobe", 32'(v), 32'b0101);
    expect_ev(1'b1, 1'b0, 4'b0100, 16'd1);
    strobe_at(340, 4'b0100);
    read_slot(20, v);  chk("t2_slot_cleared", 32'(v), 32'b0001);
    chk("t2_score", 32'(bus.score), 32'd1);
    expect_ev(1'b0, 1'b1, 4'b0000, 16'd1);
    at_cyc(355);

    // Test 3: full hit in the SHIFT cycle suppresses the miss.
    load_rom(4'b0101, 4'b0000, 4'b0000, 4'b0000);
    do_reset();
    expect_ev(1'b1, 1'b0, 4'b0101, 16'd1);
    strobe_at(352, 4'b0101);
    chk("t3_score", 32'(bus.score), 32'd1);
    chk("t3_no_miss", 32'(bus.miss), 32'd0);
    read_slot(20, v);  chk("t3_slot20", 32'(v), 32'b0000);
    at_cyc(370);

    // Test 4: pause freezes scrolling but hits still resolve.
    load_rom(4'b0011, 4'b0000, 4'b0000, 4'b0000);
    do_reset();
    at_cyc(340);
    bus.run = 1'b0;
    at_cyc(360);
    chk("t4_offset_held", 32'(bus.scroll_offset), 32'd1);
    read_slot(20, v);  chk("t4_slot_held", 32'(v), 32'b0011);
    expect_ev(1'b1, 1'b0, 4'b0010, 16'd1);
    strobe_at(365, 4'b0010);
    read_slot(20, v);  chk("t4_slot_hit", 32'(v), 32'b0001);
    at_cyc(390);
    chk("t4_offset_still", 32'(bus.scroll_offset), 32'd1);
    read_slot(20, v);  chk("t4_slot_still", 32'(v), 32'b0001);
    bus.run = 1'b1;

    // Test 5: full chart of 4'hF; eight misses, chart_done 21 shifts after addr hits 8.
    load_rom(4'hF, 4'hF, 4'hF, 4'hF);
    do_reset();
    for (int i = 0; i < 8; i++) expect_ev(1'b0, 1'b1, 4'b0000, 16'd0);
    at_cyc(113);
    chk("t5_addr7", 32'(bus.chart_addr), 32'd7);
    at_cyc(129);
    chk("t5_addr8", 32'(bus.chart_addr), 32'd8);
    at_cyc(465);
    chk("t5_done_before", 32'(bus.chart_done), 32'd0);
    at_cyc(466);
    chk("t5_done_rise", 32'(bus.chart_done), 32'd1);
    at_cyc(520);
    chk("t5_done_stays", 32'(bus.chart_done), 32'd1);
    chk("t5_addr_stays", 32'(bus.chart_addr), 32'd8);

    // Test 6: reset while the third hit is pulsing.
    load_rom(4'hF, 4'hF, 4'hF, 4'b0010);
    do_reset();
    expect_ev(1'b1, 1'b0, 4'hF, 16'd1);
    strobe_at(339, 4'hF);
    expect_ev(1'b1, 1'b0, 4'hF, 16'd2);
    strobe_at(355, 4'hF);
    expect_ev(1'b1, 1'b0, 4'hF, 16'd3);
    strobe_at(371, 4'hF);
    chk("t6_score_before", 32'(bus.score), 32'd3);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_score", 32'(bus.score), 32'd0);
    chk("t6_hit", 32'(bus.hit), 32'd0);
    chk("t6_miss", 32'(bus.miss), 32'd0);
    chk("t6_lanes", 32'(bus.hit_lanes), 32'd0);
    chk("t6_addr", 32'(bus.chart_addr), 32'd0);
    chk("t6_offset", 32'(bus.scroll_offset), 32'd0);
    begin
      logic [3:0] acc;
      acc = '0;
      for (int k = 0; k < 21; k++) begin
        read_slot(k, v);
        acc = acc | v;
      end
      chk("t6_slots_zero", 32'(acc), 32'd0);
    end
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    chk("pending_events", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
